// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   state_e         controller states (StIdle, StRun)
//   booth_op_e      per-iteration operation on the partial remainder A
//   booth_decode()  maps {Q[0], Q_1} to the operation for that iteration
package booth_pkg;

  localparam int unsigned BoothWidthDefault = 4;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  typedef enum logic [1:0] {
    OpNone,
    OpAdd,
    OpSub
  } booth_op_e;

  // 01 ends a run of ones (add M), 10 starts one (subtract M), 00/11 shift only.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    booth_op_e op;
    unique case ({q0, q_1})
      2'b01:   op = OpAdd;
      2'b10:   op = OpSub;
      default: op = OpNone;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of the
// sign-extended multiplicand into A, then arithmetic right shift of {A,Q,Q_1}.
// Ports:
//   a_i, q_i, q_1_i   current {A,Q,Q_1}; A is N+1 bits
//   m_i               multiplicand (signed, N bits)
//   a_o, q_o, q_1_o   {A,Q,Q_1} after add/sub and shift
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned N = BoothWidthDefault
) (
  input  logic [N:0]   a_i,
  input  logic [N-1:0] q_i,
  input  logic         q_1_i,
  input  logic [N-1:0] m_i,
  output logic [N:0]   a_o,
  output logic [N-1:0] q_o,
  output logic         q_1_o
);

  logic [N:0] m_ext;
  logic [N:0] sum;

  assign m_ext = {m_i[N-1], m_i};

  always_comb begin
    sum = a_i;
    unique case (booth_decode(q_i[0], q_1_i))
      OpAdd:   sum = a_i + m_ext;
      OpSub:   sum = a_i - m_ext;
      default: sum = a_i;
    endcase
  end

  // Arithmetic shift: A's sign bit is replicated, A's LSB moves into Q.
  assign a_o   = {sum[N], sum[N:1]};
  assign q_o   = {sum[0], q_i[N-1:1]};
  assign q_1_o = q_i[0];

endmodule

// File: rtl/booth.sv
// Sequential radix-2 Booth multiplier, one iteration per clock.
// salida = x * y (signed, 2N bits), valid N edges after the edge sampling start.
// Ports:
//   x, y     signed operands, latched when start is accepted
//   salida   product register, updated only on completion
//   clk      rising-edge clock
//   start    start strobe; ignored while busy and on the completion edge
//   rst_n    asynchronous active-low reset
//   busy     high while iterations are in progress
//   done     one-cycle pulse in the cycle salida is updated
// Build option: define BOOTH_RESTART_EN to let start during a run abort it and
// reload from the current x/y (except on the completion edge).
module booth
  import booth_pkg::*;
#(
  parameter int unsigned N = BoothWidthDefault
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] salida,
  input  logic           clk,
  input  logic           start,
  input  logic           rst_n,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CntW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [N-1:0]    m_q, m_d;
  logic [N-1:0]    q_q, q_d;
  logic [N:0]      a_q, a_d;
  logic            q1_q, q1_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]  salida_q, salida_d;
  logic            done_q, done_d;

  logic [N:0]      a_step;
  logic [N-1:0]    q_step;
  logic            q1_step;
  logic            last;
  logic            restart;
  logic            load;

  booth_step #(
    .N (N)
  ) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .q_1_i (q1_q),
    .m_i   (m_q),
    .a_o   (a_step),
    .q_o   (q_step),
    .q_1_o (q1_step)
  );

  assign last = (cnt_q == CntW'(1));

`ifdef BOOTH_RESTART_EN
  // The completion edge wins over a coincident restart.
  assign restart = (state_q == StRun) && start && !last;
`else
  assign restart = 1'b0;
`endif

  assign load = ((state_q == StIdle) && start) || restart;

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    q_d      = q_q;
    a_d      = a_q;
    q1_d     = q1_q;
    cnt_d    = cnt_q;
    salida_d = salida_q;
    done_d   = 1'b0;

    if (load) begin
      m_d     = x;
      q_d     = y;
      q1_d    = 1'b0;
      a_d     = '0;
      cnt_d   = CntW'(N);
      state_d = StRun;
    end else if (state_q == StRun) begin
      a_d   = a_step;
      q_d   = q_step;
      q1_d  = q1_step;
      cnt_d = cnt_q - CntW'(1);
      if (last) begin
        // {A,Q} is 2N+1 bits; its top bit only duplicates the product sign.
        salida_d = {a_step[N-1:0], q_step};
        done_d   = 1'b1;
        state_d  = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      m_q      <= '0;
      q_q      <= '0;
      a_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      salida_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      q_q      <= q_d;
      a_q      <= a_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      salida_q <= salida_d;
      done_q   <= done_d;
    end
  end

  assign salida = salida_q;
  assign busy   = (state_q == StRun);
  assign done   = done_q;

endmodule

// File: tb/tb_booth.sv
// Self-checking bench for booth (N=4): table-driven products checked through
// a scoreboard queue, plus hand-written reset, restart, done-edge and
// back-to-back sequences.
module tb_booth;

  localparam int unsigned N = 4;

  logic [N-1:0]   x, y;
  logic [2*N-1:0] salida;
  logic           clk, start, rst_n, busy, done;

  int n_vec = 0;
  int n_err = 0;

  logic [2*N-1:0] sb[$];
  logic [2*N-1:0] prev_salida = '0;

  typedef struct {
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2*N-1:0] exp;
  } vec_t;

  vec_t tbl[10];

  booth #(
    .N (N)
  ) dut (
    .x      (x),
    .y      (y),
    .salida (salida),
    .clk    (clk),
    .start  (start),
    .rst_n  (rst_n),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pops one expected product; salida must not
  // move except on a done cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
          end else begin
            check("product", 32'(salida), 32'(sb.pop_front()));
          end
        end else if (salida !== prev_salida) begin
          n_vec++;
          n_err++;
          $display("FAIL salida_stable: got %0h expected %0h (t=%0t)", salida, prev_salida,
                   $time);
        end
      end
      prev_salida = salida;
    end
  end

  // One-cycle start strobe; returns 1 time unit after the sampling edge.
  task automatic launch(input logic [N-1:0] xa, input logic [N-1:0] ya, input bit push,
                        input logic [2*N-1:0] exp);
    @(posedge clk);
    #1;
    x     = xa;
    y     = ya;
    start = 1'b1;
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = 4'($urandom);
    y     = 4'($urandom);
  endtask

  // Bounded wait for done; checks the negedge count and that busy has fallen.
  task automatic wait_done(input int exp_cyc, input string name);
    int cyc = 0;
    bit got = 0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit stayed_idle;

    tbl[0] = '{4'b0011, 4'b0100, 8'h0C};  //  3 *  5... 3*4 = 12
    tbl[1] = '{4'b1101, 4'b0101, 8'hF1};  // -3 *  5 = -15
    tbl[2] = '{4'b1000, 4'b1000, 8'h40};  // -8 * -8 = 64
    tbl[3] = '{4'b1000, 4'b0111, 8'hC8};  // -8 *  7 = -56
    tbl[4] = '{4'b0000, 4'b1111, 8'h00};  //  0 * -1 = 0
    tbl[5] = '{4'b0111, 4'b0111, 8'h31};  //  7 *  7 = 49
    tbl[6] = '{4'b1111, 4'b1111, 8'h01};  // -1 * -1 = 1
    tbl[7] = '{4'b0111, 4'b1000, 8'hC8};  //  7 * -8 = -56
    tbl[8] = '{4'b1000, 4'b0001, 8'hF8};  // -8 *  1 = -8
    tbl[9] = '{4'b0101, 4'b1010, 8'hE2};  //  5 * -6 = -30

    x = '0;
    y = '0;
    start = 1'b0;
    rst_n = 1'b0;
    #3;
    check("reset_salida", 32'(salida), 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    #14;
    rst_n = 1'b1;

    // Table products.
    for (int i = 0; i < 10; i++) begin
      launch(tbl[i].x, tbl[i].y, 1'b1, tbl[i].exp);
      check("busy_after_start", 32'(busy), 32'd1);
      wait_done(N + 1, "table");
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
    end

    // Asynchronous reset mid-run, with a nonzero product already held.
    launch(4'b0111, 4'b0111, 1'b1, 8'h31);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrun_reset_salida", 32'(salida), 32'h0);
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    launch(4'b1101, 4'b0101, 1'b1, 8'hF1);
    wait_done(N + 1, "after_reset");

    // Second start on the second cycle of a run.
`ifdef BOOTH_RESTART_EN
    launch(4'b0011, 4'b0100, 1'b0, 8'h00);
    launch(4'b0101, 4'b0101, 1'b1, 8'h19);
    wait_done(N + 1, "restart");
`else
    launch(4'b0011, 4'b0100, 1'b1, 8'h0C);
    launch(4'b0101, 4'b0101, 1'b0, 8'h00);
    wait_done(N - 1, "start_ignored");
`endif

    // Start coincident with the completion edge is ignored.
    launch(4'b0110, 4'b0011, 1'b1, 8'h12);
    repeat (N - 1) @(posedge clk);
    #1;
    x = 4'b0010;
    y = 4'b0010;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1, "start_at_done");
    stayed_idle = 1;
    repeat (8) begin
      @(negedge clk);
      if (busy) stayed_idle = 0;
    end
    check("start_at_done_ignored", 32'(stayed_idle), 32'd1);

`ifndef BOOTH_RESTART_EN
    // start held high: launches in IDLE, then again on the first IDLE edge.
    @(posedge clk);
    #1;
    x = 4'b0010;
    y = 4'b0011;
    start = 1'b1;
    sb.push_back(8'h06);
    @(posedge clk);
    #1;
    x = 4'b1101;
    y = 4'b1011;
    sb.push_back(8'h0F);
    wait_done(N + 1, "b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(N + 1, "b2b_second");
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth.md
Name: booth

Overview:
- Sequential radix-2 Booth multiplier for two's-complement operands.
- Computes salida = x * y (signed, full 2N-bit product), one Booth iteration per clock.
- Started by a single-cycle start strobe; standalone arithmetic unit fed by a controller or testbench.
- Default N=4 gives 4x4 -> 8-bit signed products.

Parameters:
- N, 4, operand width in bits (N >= 2); product width is 2N.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- x  in  N  multiplicand, signed two's complement.
- y  in  N  multiplier, signed two's complement.
- start  in  1  start strobe, sampled on rising clk edge.
- salida  out  2N  signed product register.
- busy  out  1  high while iterations are in progress.
- done  out  1  one-cycle pulse when salida is updated.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Declaration order is x, y, salida, clk, start, rst_n, busy, done, so existing positional instances of five ports remain valid.
- Reset (rst_n=0, asynchronous): salida=0, busy=0, done=0, state=IDLE. All internal registers are cleared.
- States: IDLE, RUN.
- IDLE behaviour:
  - start=1 at a rising edge latches M=x, Q=y, Q_1=0, A=0 (A is N+1 bits), count=N, busy=1, and enters RUN.
  - x and y may change freely afterwards.
- RUN behaviour, one iteration per edge:
  - {Q[0],Q_1}=01: A=A+sext(M).
  - {Q[0],Q_1}=10: A=A-sext(M).
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,Q_1} by 1 and count=count-1.
- Completion: on the edge performing the Nth iteration:
  - salida takes the low 2N bits of {A,Q} after the shift.
  - done=1 for exactly that one cycle.
  - busy=0 and state returns to IDLE.
- Latency: salida is valid N rising edges after the edge that sampled start (4 cycles for N=4).
- salida holds its value until the next completion. It does not change during RUN.
- start while busy is ignored (see Optional Feature).
- start coincident with done, i.e. the last RUN edge: the strobe is ignored. A new start is accepted from the following edge in IDLE.
- The A register is N+1 bits so a most-negative multiplicand does not overflow: -8*-8 = +64 and -8*7 = -56 are exact.
- start held high for several cycles in IDLE launches back-to-back operations. Each launch latches the x and y values present at that edge.
- Reset asserted mid-operation aborts immediately: salida=0, busy=0, done=0.

Optional Feature:
- Macro: BOOTH_RESTART_EN.
- Defined: start=1 while busy aborts the current operation and reloads from the x and y present at that edge. count resets to N, busy stays 1 and no done pulse is generated for the aborted operation.
- Undefined: start during busy is ignored and the running operation completes normally.

Decomposition:
- Package booth_pkg holds:
  - state enum typedef (IDLE, RUN);
  - localparam for the default width;
  - a function encoding the Booth decision (add/sub/none) from {Q[0],Q_1}.
- One natural sub-module, booth_step: combinational add/sub plus arithmetic shift of {A,Q,Q_1}.
- Controller, counter and registers stay in booth.

Test Plan:
- Reset: assert rst_n=0 mid-run -> salida=00000000, busy=0, done=0 immediately, without waiting for a clock.
- x=0011, y=0100, one-cycle start -> after 4 edges salida=00001100 (12), done pulses one cycle, busy falls.
- Signs: x=1101 (-3), y=0101 (5) -> salida=11110001 (-15). x=1000, y=1000 -> salida=01000000 (+64).
- Edge operands: x=1000, y=0111 -> salida=11001000 (-56). x=0000, y=1111 -> salida=00000000.
- start pulsed again at cycle 2 of a run:
  - macro undefined -> the original result appears on schedule.
  - macro defined -> only the new operands' product appears, 4 edges after the second start.
- Back-to-back: start held for 2 consecutive idle cycles with different operands -> two done pulses, each with the correct product for its operands. salida stays stable between the pulses.
